// File: rtl/min_receive_fsm_pkg.sv
// Shared definitions for the MIN frame receiver and transmitter:
// framing byte values, CRC-32 constants and the receive state encoding.
package min_receive_fsm_pkg;

    // Framing bytes
    localparam logic [7:0] MIN_SOF   = 8'hAA;
    localparam logic [7:0] MIN_STUFF = 8'h55;
    localparam logic [7:0] MIN_EOF   = 8'h55;

    // Reflected CRC-32 (IEEE 802.3)
    localparam logic [31:0] CRC32_POLY   = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;

    // Number of CRC bytes carried on the wire
    localparam int CRC_BYTES = 4;

    // Receive state encoding
    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_HDR     = 3'd1,
        ST_ID      = 3'd2,
        ST_LEN     = 3'd3,
        ST_PAYLOAD = 3'd4,
        ST_CRC     = 3'd5,
        ST_EOF     = 3'd6
    } state_t;

endpackage

// File: rtl/crc32_byte.sv
// One-byte update of a reflected CRC-32 register. Purely combinational so
// the receiver and the transmitter can both fold in one byte per strobe.
module crc32_byte
    import min_receive_fsm_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] next_crc
);

    // Shift the byte in LSB first, eight conditional polynomial reductions
    always_comb begin
        // NOTE: next_crc gets a full value before the loop, so no path leaves it unassigned and no latch is inferred.
        next_crc = crc ^ {24'h00_0000, data};
        for (int i = 0; i < 8; i++) begin
            if (next_crc[0]) begin
                next_crc = (next_crc >> 1) ^ CRC32_POLY;
            end else begin
                next_crc = next_crc >> 1;
            end
        end
    end

endmodule

// File: rtl/min_receive_fsm.sv
// MIN frame receiver. Hunts for the triple 0xAA header, removes byte
// stuffing from the frame body, checks CRC-32 and EOF, and presents each
// good frame as a one-cycle o_valid with ID, length and payload held until
// the next good frame. Payload is collected in a shadow buffer so a failing
// frame never disturbs the last good o_data.
module min_receive_fsm
    import min_receive_fsm_pkg::*;
#(
    parameter int MAX_PAYLOAD  = 8,
    parameter bit ID_FILTER_EN = 1'b0
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic                     i_valid,
    input  logic [7:0]               i_data,
    input  logic [7:0]               i_id,
    output logic                     o_valid,
    output logic [7:0]               o_id,
    output logic [7:0]               o_len,
    output logic [MAX_PAYLOAD*8-1:0] o_data,
    output logic                     o_crc_err,
    output logic                     o_len_err,
    output logic                     o_busy
);

    localparam int         IDX_W   = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

    state_t      state;
    logic [1:0]  aa_cnt;      // consecutive 0xAA bytes seen in the frame body
    logic [7:0]  cnt;         // header AA count, payload index or CRC byte index
    logic [7:0]  rx_id;
    logic [7:0]  rx_len;
    logic [31:0] rx_crc;      // received CRC, shifted in MSB first
    logic [31:0] crc;         // running CRC over unstuffed ID, LEN, payload
    logic [31:0] crc_next;

    logic [7:0]               shadow [MAX_PAYLOAD];
    logic [MAX_PAYLOAD*8-1:0] shadow_flat;

    logic take;
    logic in_body;
    logic frame_start;
    logic pay_wr;
    logic crc_ok;
    logic id_pass;

    assign take    = i_valid & i_en;
    assign in_body = (state != ST_HUNT) && (state != ST_HDR);

    // Third 0xAA of a header, either from hunting or as a resync inside a body
    assign frame_start = take && (i_data == MIN_SOF) &&
                         (((state == ST_HDR) && (cnt == 8'd2)) ||
                          (in_body && (aa_cnt == 2'd2)));

    // A payload byte is real data unless it follows two body 0xAA bytes
    assign pay_wr = take && (state == ST_PAYLOAD) && (aa_cnt != 2'd2);

    assign crc_ok  = (rx_crc == (crc ^ CRC32_XOROUT));
    assign id_pass = (ID_FILTER_EN == 1'b0) || (rx_id == i_id);
    assign o_busy  = (state != ST_HUNT);

    crc32_byte u_crc (
        .crc      (crc),
        .data     (i_data),
        .next_crc (crc_next)
    );

    // Flatten the shadow buffer with byte 0 in the most significant byte
    always_comb begin
        shadow_flat = '0;
        for (int i = 0; i < MAX_PAYLOAD; i++) begin
            shadow_flat[(MAX_PAYLOAD-1-i)*8 +: 8] = shadow[i];
        end
    end

    // Shadow payload buffer: cleared at every frame start so unused bytes read zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: the buffer is only a few bytes and must read zero for short frames, so it is reset along with the control state.
            for (int i = 0; i < MAX_PAYLOAD; i++) begin
                shadow[i] <= '0;
            end
        end else if (frame_start) begin
            for (int i = 0; i < MAX_PAYLOAD; i++) begin
                shadow[i] <= '0;
            end
        end else if (pay_wr) begin
            shadow[cnt[IDX_W-1:0]] <= i_data;
        end
    end

    // Receive FSM with unstuffing, CRC accumulation and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
            state     <= ST_HUNT;
            aa_cnt    <= '0;
            cnt       <= '0;
            rx_id     <= '0;
            rx_len    <= '0;
            rx_crc    <= '0;
            crc       <= CRC32_INIT;
            o_valid   <= 1'b0;
            o_id      <= '0;
            o_len     <= '0;
            o_data    <= '0;
            o_crc_err <= 1'b0;
            o_len_err <= 1'b0;
        end else begin
            o_valid   <= 1'b0;
            o_crc_err <= 1'b0;
            o_len_err <= 1'b0;

            if (take) begin
                if (frame_start) begin
                    state  <= ST_ID;
                    cnt    <= '0;
                    aa_cnt <= '0;
                    crc    <= CRC32_INIT;
                end else begin
                    case (state)
                        ST_HUNT: begin
                            if (i_data == MIN_SOF) begin
                                state <= ST_HDR;
                                cnt   <= 8'd1;
                            end
                        end

                        ST_HDR: begin
                            if (i_data == MIN_SOF) begin
                                cnt <= cnt + 8'd1;
                            end else begin
                                state <= ST_HUNT;
                            end
                        end

                        default: begin
                            if (aa_cnt == 2'd2) begin
                                // Stuff byte is dropped; anything else aborts silently
                                aa_cnt <= '0;
                                if (i_data != MIN_STUFF) begin
                                    state <= ST_HUNT;
                                end
                            end else begin
                                aa_cnt <= (i_data == MIN_SOF) ? aa_cnt + 2'd1 : 2'd0;
                                case (state)
                                    ST_ID: begin
                                        rx_id <= i_data;
                                        crc   <= crc_next;
                                        state <= ST_LEN;
                                    end

                                    ST_LEN: begin
                                        if (i_data > MAX_LEN) begin
                                            o_len_err <= 1'b1;
                                            aa_cnt    <= '0;
                                            state     <= ST_HUNT;
                                        end else begin
                                            rx_len <= i_data;
                                            crc    <= crc_next;
                                            cnt    <= '0;
                                            state  <= (i_data == 8'd0) ? ST_CRC : ST_PAYLOAD;
                                        end
                                    end

                                    ST_PAYLOAD: begin
                                        crc <= crc_next;
                                        if (cnt == rx_len - 8'd1) begin
                                            cnt   <= '0;
                                            state <= ST_CRC;
                                        end else begin
                                            cnt <= cnt + 8'd1;
                                        end
                                    end

                                    ST_CRC: begin
                                        rx_crc <= {rx_crc[23:0], i_data};
                                        if (cnt == 8'(CRC_BYTES - 1)) begin
                                            cnt   <= '0;
                                            state <= ST_EOF;
                                        end else begin
                                            cnt <= cnt + 8'd1;
                                        end
                                    end

                                    ST_EOF: begin
                                        state  <= ST_HUNT;
                                        aa_cnt <= '0;
                                        if (id_pass) begin
                                            if ((i_data == MIN_EOF) && crc_ok) begin
                                                o_valid <= 1'b1;
                                                o_id    <= rx_id;
                                                o_len   <= rx_len;
                                                o_data  <= shadow_flat;
                                            end else begin
                                                o_crc_err <= 1'b1;
                                            end
                                        end
                                    end

                                    default: begin
                                        state <= ST_HUNT;
                                    end
                                endcase
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_min_receive_fsm.sv
// Scoreboard bench for min_receive_fsm. The stimulus side builds stuffed
// frames from directed vectors and pushes the expected pulse (kind, cycle,
// ID, length, payload) into a queue; a monitor pops and compares whenever
// the DUT raises o_valid, o_crc_err or o_len_err. A second instance with
// ID filtering enabled counts its accepted frames.
module tb_min_receive_fsm;

    localparam int MP = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          en    = 1'b1;
    logic          vld   = 1'b0;
    logic [7:0]    data  = 8'h00;
    logic [7:0]    id_cfg = 8'h01;

    logic          m_valid, m_crc_err, m_len_err, m_busy;
    logic [7:0]    m_id, m_len;
    logic [MP*8-1:0] m_data;

    logic          f_valid, f_crc_err, f_len_err, f_busy;
    logic [7:0]    f_id, f_len;
    logic [MP*8-1:0] f_data;

    min_receive_fsm #(.MAX_PAYLOAD(MP), .ID_FILTER_EN(1'b0)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_valid(vld), .i_data(data), .i_id(id_cfg),
        .o_valid(m_valid), .o_id(m_id), .o_len(m_len), .o_data(m_data),
        .o_crc_err(m_crc_err), .o_len_err(m_len_err), .o_busy(m_busy)
    );

    min_receive_fsm #(.MAX_PAYLOAD(MP), .ID_FILTER_EN(1'b1)) u_flt (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_valid(vld), .i_data(data), .i_id(id_cfg),
        .o_valid(f_valid), .o_id(f_id), .o_len(f_len), .o_data(f_data),
        .o_crc_err(f_crc_err), .o_len_err(f_len_err), .o_busy(f_busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;   // 1 = valid, 2 = crc error, 3 = length error
        int unsigned due;
        logic [7:0]  id;
        logic [7:0]  len;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    logic [7:0]  good_id   = 8'h00;
    logic [7:0]  good_len  = 8'h00;
    logic [63:0] good_data = 64'h0;
    int          flt_exp   = 0;
    int          flt_seen  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Bit-serial reference CRC-32, LSB first
    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int j = 0; j < 8; j++) begin
            fb = r[0] ^ b[j];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB8_8320;
        end
        return r;
    endfunction

    task automatic put_byte(input logic [7:0] b, input logic e);
        @(negedge clk);
        en   = e;
        vld  = 1'b1;
        data = b;
    endtask

    task automatic gap_wait(input int g);
        if (g > 0) begin
            @(negedge clk);
            vld = 1'b0;
            repeat (g - 1) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        vld = 1'b0;
        en  = 1'b1;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_o_valid"},   m_valid,   0);
        check({tag, "_o_id"},      m_id,      0);
        check({tag, "_o_len"},     m_len,     0);
        check({tag, "_o_data"},    m_data,    0);
        check({tag, "_o_crc_err"}, m_crc_err, 0);
        check({tag, "_o_len_err"}, m_len_err, 0);
        check({tag, "_o_busy"},    m_busy,    0);
    endtask

    // mode: 0 good, 1 CRC LSB flipped, 2 bad EOF byte, 3 header+ID+LEN only (length error)
    task automatic send_frame(input logic [7:0] id, input logic [7:0] len, input logic [63:0] pl,
                              input int mode, input int gap, input int abort_at, input int en_at);
        logic [7:0]  body[$];
        logic [7:0]  strm[$];
        logic [31:0] c;
        logic [7:0]  b;
        int          aa;
        int          trig;
        exp_t        e;

        body.push_back(id);
        body.push_back(len);
        if (mode != 3) begin
            for (int i = 0; i < int'(len); i++) begin
                b = pl[63-8*i -: 8];
                body.push_back(b);
            end
            c = 32'hFFFF_FFFF;
            foreach (body[i]) c = crc_upd(c, body[i]);
            c = c ^ 32'hFFFF_FFFF;
            if (mode == 1) c[0] = ~c[0];
            body.push_back(c[31:24]);
            body.push_back(c[23:16]);
            body.push_back(c[15:8]);
            body.push_back(c[7:0]);
        end

        strm = '{8'hAA, 8'hAA, 8'hAA};
        aa   = 0;
        foreach (body[i]) begin
            strm.push_back(body[i]);
            aa = (body[i] == 8'hAA) ? aa + 1 : 0;
            if (aa == 2) begin
                strm.push_back(8'h55);
                aa = 0;
            end
        end
        if (mode != 3) strm.push_back((mode == 2) ? 8'h33 : 8'h55);

        trig = (mode == 3) ? 4 : strm.size() - 1;

        e.kind = (mode == 0) ? 1 : ((mode == 3) ? 3 : 2);
        if (mode == 0) begin
            e.id = id; e.len = len; e.data = pl;
        end else begin
            e.id = good_id; e.len = good_len; e.data = good_data;
        end

        foreach (strm[i]) begin
            if (i == abort_at) return;
            if (i == en_at) begin
                put_byte(8'hAA, 1'b0);
                put_byte(8'h13, 1'b0);
                put_byte(8'hAA, 1'b0);
            end
            put_byte(strm[i], 1'b1);
            if (i == trig) begin
                e.due = cyc + 1;
                sb.push_back(e);
                if (mode == 0) begin
                    good_id = id; good_len = len; good_data = pl;
                    if (id == 8'h01) flt_exp++;
                end
                if (mode == 3) return;
            end
            gap_wait(gap);
        end
    endtask

    // Monitor: pop one expectation per output pulse
    int   mon_n;
    int   mon_k;
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (f_valid) flt_seen++;
            mon_n = int'(m_valid) + int'(m_crc_err) + int'(m_len_err);
            if (mon_n > 0) begin
                mon_k = m_valid ? 1 : (m_crc_err ? 2 : 3);
                check("pulse_exclusive", mon_n, 1);
                if (sb.size() == 0) begin
                    check("unexpected_pulse_kind", mon_k, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("pulse_kind",  mon_k,  mon_e.kind);
                    check("pulse_cycle", cyc,    mon_e.due);
                    check("o_id",        m_id,   mon_e.id);
                    check("o_len",       m_len,  mon_e.len);
                    check("o_data",      m_data, mon_e.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [31:0] c;
        logic [7:0]  s[9];

        // Reference model sanity: CRC-32 of "123456789" is 0xCBF43926
        s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        c = 32'hFFFF_FFFF;
        foreach (s[i]) c = crc_upd(c, s[i]);
        if ((c ^ 32'hFFFF_FFFF) != 32'hCBF4_3926) begin
            $display("FAIL crc_model: got %0h want cbf43926", c ^ 32'hFFFF_FFFF);
            $fatal(1);
        end

        // Reset state
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        idle(3);

        // Basic frame, one byte every 166 cycles
        send_frame(8'h01, 8'd4, 64'h1234_5678_0000_0000, 0, 165, -1, -1);
        idle(4);
        check("busy_idle", m_busy, 0);

        // Payload needing a stuff byte: AA AA 55 55 01 on the wire
        send_frame(8'h01, 8'd4, 64'hAAAA_5501_0000_0000, 0, 2, -1, -1);
        idle(4);

        // CRC LSB flipped, then bad EOF byte: o_data must keep AAAA5501
        send_frame(8'h01, 8'd4, 64'h1234_5678_0000_0000, 1, 1, -1, -1);
        idle(4);
        send_frame(8'h01, 8'd4, 64'h1234_5678_0000_0000, 2, 0, -1, -1);
        idle(4);

        // LEN above MAX_PAYLOAD, then a good frame
        send_frame(8'h02, 8'd9, 64'h0, 3, 0, -1, -1);
        idle(3);
        send_frame(8'h03, 8'd2, 64'h0A0B_0000_0000_0000, 0, 0, -1, -1);
        idle(4);

        // Zero-length and full-length payloads
        send_frame(8'h04, 8'd0, 64'h0, 0, 1, -1, -1);
        idle(4);
        send_frame(8'h05, 8'd8, 64'h0102_0304_0506_0708, 0, 0, -1, -1);
        idle(4);

        // Foreign ID: accepted by the unfiltered instance only
        send_frame(8'h22, 8'd3, 64'hC0FF_EE00_0000_0000, 0, 0, -1, -1);
        idle(4);

        // Truncated after two payload bytes, next frame back-to-back
        send_frame(8'h07, 8'd4, 64'h1122_3344_0000_0000, 0, 0, 7, -1);
        send_frame(8'h06, 8'd3, 64'h9ABC_DE00_0000_0000, 0, 0, -1, -1);
        idle(4);

        // Bytes strobed while i_en is low are dropped mid-payload
        send_frame(8'h01, 8'd4, 64'hDEAD_BEEF_0000_0000, 0, 1, -1, 7);
        idle(4);

        // Reset in the middle of the CRC bytes
        send_frame(8'h01, 8'd4, 64'h1234_5678_0000_0000, 0, 0, 11, -1);
        @(negedge clk);
        vld = 1'b0;
        check("busy_mid_frame", m_busy, 1);
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        good_id   = 8'h00;
        good_len  = 8'h00;
        good_data = 64'h0;
        idle(10);
        send_frame(8'h01, 8'd4, 64'h1234_5678_0000_0000, 0, 0, -1, -1);
        idle(6);

        check("busy_end",        m_busy,    0);
        check("filtered_frames", flt_seen,  flt_exp);
        check("pending_expects", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
